// File: rtl/scan_sequencer.sv
// scan_sequencer
//   Control stage in front of a 3-to-8 one-hot decoder. It walks through the
//   channels selected by a mask, from the lowest to the highest. Each channel
//   is held for (dwell+1) cycles. A one-cycle blanking gap separates two
//   channels so the decoder never drives two lines at once.
//   The block supports a single pass (one-shot) or continuous scanning.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   start      single-cycle scan request; ignored while busy or with an empty mask
//   stop       abort; the block returns to idle on the next edge (wins over start)
//   mode_once  1 = one pass then done, 0 = continuous; sampled with start
//   chan_mask  channel enable bits; sampled with start
//   dwell      hold time minus one; sampled with start
//   sel        channel index to the decoder
//   sel_en     decoder enable
//   busy       scan in progress
//   done       one-cycle pulse at the end of a one-shot pass
//   wrap       one-cycle pulse in the gap where a continuous scan wraps around
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_once,
    input  logic [7:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_en,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         sel_reg, sel_next;
    logic               sel_en_reg, sel_en_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               wrap_reg, wrap_next;
    logic [7:0]         mask_reg, mask_next;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;
    logic               once_reg, once_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;

    // Index of the lowest set bit; 0 for an empty vector.
    function automatic logic [2:0] lowest(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Latched channels strictly above the one currently selected.
    logic [7:0] above_sel;
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_above
            assign above_sel[gi] = mask_reg[gi] && (3'(gi) > sel_reg);
        end
    endgenerate

    logic       has_next;
    logic [2:0] next_chan;
    logic [2:0] first_chan;
    logic [2:0] start_chan;

    assign has_next   = |above_sel;
    assign next_chan  = lowest(above_sel);
    assign first_chan = lowest(mask_reg);
    assign start_chan = lowest(chan_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            sel_reg    <= 3'd0;
            sel_en_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            wrap_reg   <= 1'b0;
            mask_reg   <= 8'd0;
            dwell_reg  <= '0;
            once_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            sel_en_reg <= sel_en_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            wrap_reg   <= wrap_next;
            mask_reg   <= mask_next;
            dwell_reg  <= dwell_next;
            once_reg   <= once_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        sel_en_next = sel_en_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        wrap_next   = 1'b0;
        mask_next   = mask_reg;
        dwell_next  = dwell_reg;
        once_next   = once_reg;
        cnt_next    = cnt_reg;

        case (state_reg)
            IDLE: begin
                sel_next    = 3'd0;
                sel_en_next = 1'b0;
                busy_next   = 1'b0;
                if (start && !stop && (chan_mask != 8'd0)) begin
                    state_next  = ACTIVE;
                    mask_next   = chan_mask;
                    dwell_next  = dwell;
                    once_next   = mode_once;
                    sel_next    = start_chan;
                    sel_en_next = 1'b1;
                    busy_next   = 1'b1;
                    cnt_next    = '0;
                end
            end
            ACTIVE: begin
                if (stop) begin
                    state_next  = IDLE;
                    sel_next    = 3'd0;
                    sel_en_next = 1'b0;
                    busy_next   = 1'b0;
                end else if (cnt_reg == dwell_reg) begin
                    // Counting 0..dwell in place (never to dwell+1) keeps the
                    // maximum dwell inside DWELL_W bits.
                    sel_en_next = 1'b0;
                    if (has_next) begin
                        state_next = GAP;
                        sel_next   = next_chan;
                    end else if (!once_reg) begin
                        state_next = GAP;
                        sel_next   = first_chan;
                        wrap_next  = 1'b1;
                    end else begin
                        state_next = IDLE;
                        sel_next   = 3'd0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (stop) begin
                    state_next  = IDLE;
                    sel_next    = 3'd0;
                    sel_en_next = 1'b0;
                    busy_next   = 1'b0;
                end else begin
                    state_next  = ACTIVE;
                    sel_en_next = 1'b1;
                    cnt_next    = '0;
                end
            end
            default: begin
                state_next  = IDLE;
                sel_next    = 3'd0;
                sel_en_next = 1'b0;
                busy_next   = 1'b0;
            end
        endcase
    end

    assign sel    = sel_reg;
    assign sel_en = sel_en_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign wrap   = wrap_reg;

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream control stage for the 3-to-8 one-hot decoder. Generates the 3-bit channel index and enable that drive the decoder.
- Steps through a masked subset of 8 channels. Each channel is held for a programmable dwell time, with a one-cycle blanking gap between channels so the decoder output never glitches between two active lines.
- Supports one-shot and continuous scanning. Used for LED/keypad-style row scanning and time-multiplexed channel selection.

Parameters:
DWELL_W, 8, width of the dwell-count input and internal dwell counter

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle request to begin a scan; ignored while busy
stop  input  1  abort request; returns the block to IDLE on the next edge
mode_once  input  1  1 = one pass then stop; 0 = continuous; sampled with start
chan_mask  input  8  bit i = 1 means channel i is scanned; sampled with start
dwell  input  DWELL_W  channel hold time minus 1; sampled with start
sel  output  3  channel index to the decoder input
sel_en  output  1  enable to the decoder
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse when a one-shot pass completes
wrap  output  1  one-cycle pulse when a continuous scan wraps to its first channel

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, sel=0, sel_en=0, busy=0, done=0, wrap=0, latched mask/dwell/mode=0. Reset mid-scan aborts immediately, with no done or wrap pulse.
- States: IDLE, ACTIVE, GAP.
- IDLE:
  - sel=0, sel_en=0, busy=0.
  - On start=1, stop=0, chan_mask!=0: latch chan_mask, dwell and mode_once, then go to ACTIVE.
  - start with chan_mask==0 is ignored: stays IDLE, no pulses.
- Start latency: start sampled at edge T. From cycle T+1, sel=lowest set bit of the latched mask, sel_en=1, busy=1.
- ACTIVE:
  - sel_en=1 for exactly dwell+1 cycles. dwell=0 gives 1 cycle; dwell=2^DWELL_W-1 gives 2^DWELL_W cycles, with no counter overflow.
  - At the end of the dwell:
    - If there is a higher set bit in the latched mask: go to GAP with sel=next higher set channel.
    - Else, continuous mode: go to GAP with sel=lowest set channel and wrap=1 during that GAP cycle.
    - Else, one-shot mode: go to IDLE. done=1 and busy=0 in that first IDLE cycle, and sel returns to 0.
- GAP: exactly one cycle, sel_en=0, busy=1, sel already holds the next channel. Then ACTIVE.
- Single-bit mask, continuous: the same channel repeats with a gap each period, and wrap pulses in every gap.
- Mid-scan input changes: chan_mask, dwell and mode_once changes while busy have no effect until the next start.
- start while busy is ignored.
- stop=1 while busy:
  - Next cycle is IDLE: sel_en=0, sel=0, busy=0, no done.
  - stop in the same cycle as a dwell end still aborts, with no done or wrap.
- start and stop together in IDLE: stop wins and start is ignored.
- Output invariants:
  - done and wrap are never high simultaneously and are never high for more than one consecutive cycle.
  - sel only changes while sel_en=0, or on the ACTIVE→IDLE and ACTIVE→GAP edges, so sel never changes while sel_en stays high.
- All outputs are registered.

Test Plan:
1. One-shot: rst, then chan_mask=8'b00000101, dwell=2, mode_once=1, start at edge 0 → sel=0, sel_en=1 cycles 1–3; cycle 4 sel=2, sel_en=0; cycles 5–7 sel=2, sel_en=1; cycle 8 done=1, busy=0, sel=0; cycle 9 done=0.
2. Continuous wrap: chan_mask=8'b10000010, dwell=0, mode_once=0 → pattern repeats every 4 cycles: sel 1 (en), gap→7, sel 7 (en), gap→1 with wrap=1; wrap never asserts in the 1→7 gap; busy stays 1.
3. Stop mid-dwell: chan_mask=8'hFF, dwell=5, continuous; assert stop on the 3rd cycle of channel 4 → next cycle sel_en=0, sel=0, busy=0; done and wrap stay 0; a new start resumes from channel 0.
4. Degenerate inputs: start with chan_mask=0 → busy stays 0, no pulses. Single mask 8'b00001000, dwell=0, continuous → sel constant 3, sel_en toggles 1,0,1,0, wrap=1 in each gap.
5. Mid-scan input changes: while busy, change chan_mask and dwell and pulse start → scan order and dwell are unchanged. start+stop together in IDLE → stays IDLE.
6. Reset mid-operation: assert rst during a GAP cycle → next cycle all outputs at reset values. Max dwell (DWELL_W=8, dwell=255) → sel_en held exactly 256 cycles.
